button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream conditioner for the two board push-buttons, MOVE and SELECT. These buttons are active-low and bouncy.
- Synchronises each raw input, debounces it, and converts each accepted press into a single-cycle, active-high pulse.
- Its pulses drive the move/select inputs of the card-game move FSM and the press-counting machine directly, so no inversion is needed at the top level.
- Runs on the regulated game clock.

Parameters:
- DB_COUNT, 250000: consecutive stable cycles required to accept a level change. Simulation uses 4.
- CNT_W, 18: debounce counter width. Must satisfy 2^CNT_W > DB_COUNT.

Ports:
- clk  in  1  regulated game clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- move_n  in  1  raw MOVE button, 0 = pressed, asynchronous to clk
- select_n  in  1  raw SELECT button, 0 = pressed, asynchronous to clk
- move_pulse  out  1  one-cycle high per accepted MOVE press
- select_pulse  out  1  one-cycle high per accepted SELECT press
- move_held  out  1  debounced MOVE level, 1 = pressed
- select_held  out  1  debounced SELECT level, 1 = pressed
- press_count  out  8  total pulses issued on both buttons, for the 7-seg debug display

Behaviour:
- Reset is asynchronous on rst=0. Every output reads 0, all FSMs go to IDLE, counters clear, the pending flag clears, and synchroniser flops load 1 (released). Release of reset is synchronous to clk.
- Synchroniser: two flops per button. Downstream logic sees only the second stage, s_x.
- Per-button FSM, with an independent instance for each button:
  - IDLE (released, stable): s_x=0 -> PRESS_WAIT with cnt=1. Otherwise stay, cnt=0.
  - PRESS_WAIT:
    - s_x=1 (released again) -> IDLE, cnt=0. A bounce restarts the count.
    - s_x=0 and cnt==DB_COUNT-1 -> HELD, and raise an event for this cycle.
    - Otherwise cnt+1.
  - HELD (pressed, stable): x_held=1. s_x=1 -> RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: x_held stays 1.
    - s_x=0 -> HELD, cnt=0.
    - s_x=1 and cnt==DB_COUNT-1 -> IDLE, x_held=0. No pulse on release.
    - Otherwise cnt+1.
- Latency: if the raw input goes low and stays low, the pulse is high exactly DB_COUNT+3 rising edges after the first edge that samples it low. The pulse lasts exactly one cycle.
- A button held indefinitely produces one pulse and no auto-repeat. A new pulse requires a full debounced release followed by a full debounced press.
- Output stage (registered; one pulse per cycle max):
  - If the select event and move event occur in the same cycle:
    - select_pulse=1 that cycle.
    - Move is stored in move_pend.
    - move_pulse=1 on the next cycle.
  - If move_pend is set and a new select event occurs, select wins again and move stays pending. move_pend is never lost and never duplicated.
  - move_pulse and select_pulse are never high in the same cycle.
- press_count increments by 1 on every cycle in which either pulse is high. It wraps from 255 to 0.
- Reset mid-debounce or mid-pending discards the partial count and any pending move. No pulse is emitted after reset release unless a fresh full debounce completes.

Test Plan (DB_COUNT=4):
1. Reset -> all outputs 0. Then hold move_n=0 from edge 0 -> move_pulse=1 only in the cycle after edge 7, move_held=1 from the same cycle, press_count=1.
2. Bounce on move_n: 0,1,0,1 one cycle each, then steady 0 -> exactly one move_pulse, 7 edges after the start of the steady 0. No pulse during the bounce.
3. Hold select_n=0 for 50 cycles, release, bounce on release, then press again -> exactly 2 select_pulse and no pulse on release. select_held drops 4 cycles after the stable release reaches the synchroniser output.
4. move_n and select_n fall on the same edge -> select_pulse in cycle N and move_pulse in cycle N+1, never overlapping. press_count goes 0->1->2.
5. Drive 256 accepted presses -> press_count returns to 0 after the 256th.
6. Assert rst=0 asynchronously mid-PRESS_WAIT and also during a pending move -> outputs 0 immediately and no pulse after release while inputs stay high.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button-side bundle of the push-button conditioner: raw active-low inputs in,
// debounced levels, one-cycle press pulses and the pulse counter out.
`timescale 1ns/1ps
interface button_conditioner_if;
   logic       move_n;
   logic       select_n;
   logic       move_pulse;
   logic       select_pulse;
   logic       move_held;
   logic       select_held;
   logic [7:0] press_count;

   modport master (
      output move_n,
      output select_n,
      input  move_pulse,
      input  select_pulse,
      input  move_held,
      input  select_held,
      input  press_count
   );

   modport slave (
      input  move_n,
      input  select_n,
      output move_pulse,
      output select_pulse,
      output move_held,
      output select_held,
      output press_count
   );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and pulse-converts the MOVE and SELECT push-buttons,
// arbitrating simultaneous presses so at most one pulse leaves per cycle.
//
// state        | meaning
// IDLE         | released and stable
// PRESS_WAIT   | synchronised input low, counting stable-low cycles
// HELD         | pressed and stable, press already reported
// RELEASE_WAIT | synchronised input high, counting stable-high cycles
`timescale 1ns/1ps
module button_conditioner #(
   parameter int unsigned DB_COUNT = 250000,
   parameter int unsigned CNT_W    = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   button_conditioner_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_e;

   localparam int unsigned      N_BTN    = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Bit 0 is MOVE, bit 1 is SELECT throughout.
   logic [N_BTN-1:0] raw_n;
   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;

   db_state_e        state_q [N_BTN];
   db_state_e        state_d [N_BTN];
   logic [CNT_W-1:0] cnt_q   [N_BTN];
   logic [CNT_W-1:0] cnt_d   [N_BTN];

   logic [N_BTN-1:0] evt_d;
   logic [N_BTN-1:0] evt_q;
   logic [N_BTN-1:0] evt_dly_q;
   logic [N_BTN-1:0] held_pre_q;
   logic [N_BTN-1:0] held_d;
   logic [N_BTN-1:0] held_q;

   logic             move_pend_d;
   logic             move_pend_q;
   logic             move_pulse_d;
   logic             move_pulse_q;
   logic             select_pulse_d;
   logic             select_pulse_q;
   logic [7:0]       press_count_d;
   logic [7:0]       press_count_q;

   function automatic logic is_pressed_state(input db_state_e s);
      return (s == HELD) || (s == RELEASE_WAIT);
   endfunction

   assign raw_n = {bus.select_n, bus.move_n};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= raw_n;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      for (int b = 0; b < N_BTN; b++) begin
         state_d[b] = state_q[b];
         cnt_d[b]   = cnt_q[b];
         evt_d[b]   = 1'b0;
         unique case (state_q[b])
            IDLE: begin
               if (!sync2_q[b]) begin
                  state_d[b] = PRESS_WAIT;
                  cnt_d[b]   = CNT_ONE;
               end else begin
                  cnt_d[b]   = '0;
               end
            end
            PRESS_WAIT: begin
               if (sync2_q[b]) begin
                  state_d[b] = IDLE;
                  cnt_d[b]   = '0;
               end else if (cnt_q[b] == CNT_LAST) begin
                  state_d[b] = HELD;
                  cnt_d[b]   = '0;
                  evt_d[b]   = 1'b1;
               end else begin
                  cnt_d[b]   = cnt_q[b] + CNT_ONE;
               end
            end
            HELD: begin
               if (sync2_q[b]) begin
                  state_d[b] = RELEASE_WAIT;
                  cnt_d[b]   = CNT_ONE;
               end else begin
                  cnt_d[b]   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (!sync2_q[b]) begin
                  state_d[b] = HELD;
                  cnt_d[b]   = '0;
               end else if (cnt_q[b] == CNT_LAST) begin
                  state_d[b] = IDLE;
                  cnt_d[b]   = '0;
               end else begin
                  cnt_d[b]   = cnt_q[b] + CNT_ONE;
               end
            end
            default: begin
               state_d[b] = IDLE;
               cnt_d[b]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < N_BTN; b++) begin
            state_q[b] <= IDLE;
            cnt_q[b]   <= '0;
         end
      end else begin
         for (int b = 0; b < N_BTN; b++) begin
            state_q[b] <= state_d[b];
            cnt_q[b]   <= cnt_d[b];
         end
      end
   end

   // The held level rises in step with the press pulse (two stages behind the
   // FSM) but drops on the very edge the release is accepted.
   always_comb begin
      for (int b = 0; b < N_BTN; b++) begin
         held_d[b] = held_pre_q[b] & is_pressed_state(state_d[b]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         evt_q      <= '0;
         evt_dly_q  <= '0;
         held_pre_q <= '0;
         held_q     <= '0;
      end else begin
         evt_q      <= evt_d;
         evt_dly_q  <= evt_q;
         for (int b = 0; b < N_BTN; b++) begin
            held_pre_q[b] <= is_pressed_state(state_q[b]);
         end
         held_q     <= held_d;
      end
   end

   // SELECT has priority; a colliding MOVE is parked in move_pend and goes out
   // on the first cycle without a SELECT event.
   always_comb begin
      move_pulse_d   = 1'b0;
      select_pulse_d = 1'b0;
      move_pend_d    = move_pend_q;
      if (evt_dly_q[1]) begin
         select_pulse_d = 1'b1;
         if (evt_dly_q[0]) begin
            move_pend_d = 1'b1;
         end
      end else if (evt_dly_q[0]) begin
         move_pulse_d = 1'b1;
      end else if (move_pend_q) begin
         move_pulse_d = 1'b1;
         move_pend_d  = 1'b0;
      end
      press_count_d = press_count_q;
      if (move_pulse_d || select_pulse_d) begin
         press_count_d = press_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         move_pend_q    <= 1'b0;
         move_pulse_q   <= 1'b0;
         select_pulse_q <= 1'b0;
         press_count_q  <= '0;
      end else begin
         move_pend_q    <= move_pend_d;
         move_pulse_q   <= move_pulse_d;
         select_pulse_q <= select_pulse_d;
         press_count_q  <= press_count_d;
      end
   end

   assign bus.move_pulse   = move_pulse_q;
   assign bus.select_pulse = select_pulse_q;
   assign bus.move_held    = held_q[0];
   assign bus.select_held  = held_q[1];
   assign bus.press_count  = press_count_q;

endmodule
